// File: rtl/spad_row_broadcaster.sv
`default_nettype none
// ============================================================================
// Module   : spad_row_broadcaster
// Purpose  : Read side of the input scratchpad. Walks an inclusive, wrapping
//            address range, issues one SPAD read per cycle (unless held off)
//            and broadcasts every returned word, tagged with its address and
//            a valid strobe, to all row routers in parallel.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   SPAD_DATA_WIDTH   : width of one SPAD word
//   ADDR_WIDTH        : SPAD address width
//   SPAD_READ_LATENCY : cycles from o_spad_re to valid i_spad_data (1..4)
// Ports
//   i_clk         in   clock
//   i_rst         in   synchronous active-high reset
//   i_reg_clear   in   synchronous abort, identical effect to i_rst
//   i_start       in   one-cycle pulse, latches the range and starts a pass
//   i_start_addr  in   first address of the pass
//   i_end_addr    in   last address of the pass (inclusive)
//   i_hold        in   backpressure, blocks new reads while high
//   o_spad_addr   out  SPAD read address (registered)
//   o_spad_re     out  SPAD read enable (registered)
//   i_spad_data   in   SPAD read data
//   o_data        out  broadcast word
//   o_addr        out  address of the broadcast word
//   o_data_valid  out  broadcast strobe
//   o_busy        out  high while reading or draining
//   o_done        out  one-cycle pulse at the end of a pass
// ============================================================================
module spad_row_broadcaster #(
   parameter int SPAD_DATA_WIDTH   = 64,
   parameter int ADDR_WIDTH        = 8,
   parameter int SPAD_READ_LATENCY = 1
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_reg_clear,
   input  logic                       i_start,
   input  logic [ADDR_WIDTH-1:0]      i_start_addr,
   input  logic [ADDR_WIDTH-1:0]      i_end_addr,
   input  logic                       i_hold,
   output logic [ADDR_WIDTH-1:0]      o_spad_addr,
   output logic                       o_spad_re,
   input  logic [SPAD_DATA_WIDTH-1:0] i_spad_data,
   output logic [SPAD_DATA_WIDTH-1:0] o_data,
   output logic [ADDR_WIDTH-1:0]      o_addr,
   output logic                       o_data_valid,
   output logic                       o_busy,
   output logic                       o_done
);

   // ------------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------------
   localparam int                    CNT_WIDTH  = ADDR_WIDTH + 1;
   localparam int                    PIPE_LAST  = SPAD_READ_LATENCY - 1;
   localparam logic [ADDR_WIDTH-1:0] C_ADDR_ONE = ADDR_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0]  C_CNT_ONE  = CNT_WIDTH'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   state_e                     state_q;
   logic [ADDR_WIDTH-1:0]      cur_addr_q;
   logic [CNT_WIDTH-1:0]       count_q;
   logic [ADDR_WIDTH-1:0]      o_spad_addr_q;
   logic                       o_spad_re_q;
   logic                       o_busy_q;
   logic                       o_done_q;

   // Return pipeline: {valid, addr} travelling alongside each SPAD read.
   logic [ADDR_WIDTH:0]        pipe_q [SPAD_READ_LATENCY];

   logic [SPAD_DATA_WIDTH-1:0] o_data_q;
   logic [ADDR_WIDTH-1:0]      o_addr_q;
   logic                       o_data_valid_q;

   // ------------------------------------------------------------------------
   // Combinational helpers
   // ------------------------------------------------------------------------
   logic [CNT_WIDTH-1:0] start_count_d;
   logic                 in_flight;
   logic [ADDR_WIDTH:0]  ret_tail;

   // The count is one wider than an address so a full-wrap pass of
   // 2^ADDR_WIDTH words is representable; start == end gives one word.
   assign start_count_d = {1'b0, i_end_addr - i_start_addr} + C_CNT_ONE;

   assign ret_tail = pipe_q[PIPE_LAST];

   // A read is in flight from the cycle its enable is on the SPAD pins until
   // it leaves the last return stage. The word captured from the last stage
   // is already on the output, so it does not hold off the DONE transition;
   // that places o_done on the cycle right after the final valid.
   always_comb begin
      in_flight = o_spad_re_q;
      for (int i = 0; i < SPAD_READ_LATENCY; i++) begin
         in_flight = in_flight | pipe_q[i][ADDR_WIDTH];
      end
   end

   // ------------------------------------------------------------------------
   // Control FSM with registered read port and status outputs
   // ------------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_rst || i_reg_clear) begin
         state_q       <= ST_IDLE;
         cur_addr_q    <= '0;
         count_q       <= '0;
         o_spad_addr_q <= '0;
         o_spad_re_q   <= 1'b0;
         o_busy_q      <= 1'b0;
         o_done_q      <= 1'b0;
      end else begin
         o_spad_re_q <= 1'b0;
         o_done_q    <= 1'b0;

         case (state_q)
            ST_IDLE: begin
               if (i_start) begin
                  cur_addr_q <= i_start_addr;
                  count_q    <= start_count_d;
                  o_busy_q   <= 1'b1;
                  state_q    <= ST_READ;
               end
            end

            ST_READ: begin
               // Hold only blocks issuing; the address and count freeze.
               if (!i_hold) begin
                  o_spad_re_q   <= 1'b1;
                  o_spad_addr_q <= cur_addr_q;
                  cur_addr_q    <= cur_addr_q + C_ADDR_ONE;
                  count_q       <= count_q - C_CNT_ONE;
                  if (count_q == C_CNT_ONE) begin
                     state_q <= ST_DRAIN;
                  end
               end
            end

            ST_DRAIN: begin
               if (!in_flight) begin
                  o_busy_q <= 1'b0;
                  o_done_q <= 1'b1;
                  state_q  <= ST_DONE;
               end
            end

            ST_DONE: begin
               // Not IDLE yet, so a start arriving alongside o_done is dropped.
               state_q <= ST_IDLE;
            end

            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Return pipeline: stage 0 captures what is on the SPAD pins this cycle,
   // so the last stage lines up with i_spad_data for that read.
   // ------------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_rst || i_reg_clear) begin
         for (int i = 0; i < SPAD_READ_LATENCY; i++) begin
            pipe_q[i] <= '0;
         end
      end else begin
         pipe_q[0] <= {o_spad_re_q, o_spad_addr_q};
         for (int i = 1; i < SPAD_READ_LATENCY; i++) begin
            pipe_q[i] <= pipe_q[i-1];
         end
      end
   end

   // ------------------------------------------------------------------------
   // Broadcast register: data and address hold while no word is presented.
   // ------------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_rst || i_reg_clear) begin
         o_data_q       <= '0;
         o_addr_q       <= '0;
         o_data_valid_q <= 1'b0;
      end else begin
         o_data_valid_q <= ret_tail[ADDR_WIDTH];
         if (ret_tail[ADDR_WIDTH]) begin
            o_data_q <= i_spad_data;
            o_addr_q <= ret_tail[ADDR_WIDTH-1:0];
         end
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign o_spad_addr  = o_spad_addr_q;
   assign o_spad_re    = o_spad_re_q;
   assign o_data       = o_data_q;
   assign o_addr       = o_addr_q;
   assign o_data_valid = o_data_valid_q;
   assign o_busy       = o_busy_q;
   assign o_done       = o_done_q;

endmodule
`default_nettype wire

// File: tb/tb_spad_row_broadcaster.sv
`default_nettype none
// ============================================================================
// Module   : tb_spad_row_broadcaster
// Purpose  : Self-checking bench for spad_row_broadcaster. Two lanes run the
//            same scenario list against read latencies 1 and 3. Stimulus
//            pushes the expected address list of each pass into a queue; a
//            monitor pops it whenever a word is broadcast.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spad_row_broadcaster;

   localparam int DW = 64;
   localparam int AW = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int lanes_finished = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_lane
      localparam int LAT = (g == 0) ? 1 : 3;

      logic          rst = 1'b1;
      logic          clr = 1'b0;
      logic          start = 1'b0;
      logic          hold = 1'b0;
      logic [AW-1:0] sa = '0;
      logic [AW-1:0] ea = '0;

      logic [AW-1:0] spad_addr;
      logic          spad_re;
      logic [DW-1:0] spad_data;
      logic [DW-1:0] data;
      logic [AW-1:0] addr;
      logic          dv;
      logic          busy;
      logic          done;

      spad_row_broadcaster #(
         .SPAD_DATA_WIDTH   (DW),
         .ADDR_WIDTH        (AW),
         .SPAD_READ_LATENCY (LAT)
      ) u_dut (
         .i_clk        (clk),
         .i_rst        (rst),
         .i_reg_clear  (clr),
         .i_start      (start),
         .i_start_addr (sa),
         .i_end_addr   (ea),
         .i_hold       (hold),
         .o_spad_addr  (spad_addr),
         .o_spad_re    (spad_re),
         .i_spad_data  (spad_data),
         .o_data       (data),
         .o_addr       (addr),
         .o_data_valid (dv),
         .o_busy       (busy),
         .o_done       (done)
      );

      // SPAD macro: word content is the address byte replicated.
      function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
         return {8{a}};
      endfunction

      logic [AW:0] mem_pipe [LAT];
      always @(posedge clk) begin
         mem_pipe[0] <= {spad_re, spad_addr};
         for (int i = 1; i < LAT; i++) mem_pipe[i] <= mem_pipe[i-1];
      end
      assign spad_data = mem_pipe[LAT-1][AW] ? word_of(mem_pipe[LAT-1][AW-1:0])
                                             : 64'hBAD0_BAD0_BAD0_BAD0;

      // Reference model state
      logic [AW-1:0] exp_q[$];
      int exp_passes = 0;
      int seen_passes = 0;
      int re_cnt = 0;
      int first_re_cyc = -1;
      int first_dv_cyc = -1;
      logic hold_edge = 1'b0;
      logic prev_dv = 1'b0;

      task automatic lchk(input string name, input logic [63:0] act, input logic [63:0] exp);
         chk($sformatf("lat%0d/%s", LAT, name), act, exp);
      endtask

      always @(posedge clk) hold_edge = hold;

      // Monitor
      always @(negedge clk) begin
         logic [AW-1:0] e;
         if (spad_re) begin
            re_cnt++;
            if (first_re_cyc < 0) first_re_cyc = cyc;
         end
         if (hold_edge) lchk("no_issue_under_hold", 64'(spad_re), 64'd0);
         if (dv) begin
            if (first_dv_cyc < 0) first_dv_cyc = cyc;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL lat%0d/unexpected_word: got addr 0x%0h, required no word", LAT, addr);
            end else begin
               e = exp_q.pop_front();
               lchk("word_addr", 64'(addr), 64'(e));
               lchk("word_data", data, word_of(e));
            end
         end
         if (done) begin
            lchk("done_after_last_valid", 64'(prev_dv), 64'd1);
            lchk("done_all_words_out", 64'(exp_q.size()), 64'd0);
            if (seen_passes >= exp_passes) begin
               checks++;
               errors++;
               $display("FAIL lat%0d/unexpected_done: got done, required none (passes %0d)", LAT, exp_passes);
            end
            seen_passes++;
         end
         prev_dv = dv;
      end

      task automatic start_pass(input logic [AW-1:0] s, input logic [AW-1:0] e);
         logic [AW-1:0] a;
         logic [AW-1:0] span;
         span = e - s;
         a = s;
         for (int i = 0; i <= int'(span); i++) begin
            exp_q.push_back(a);
            a = a + 8'd1;
         end
         exp_passes++;
         sa = s;
         ea = e;
         start = 1'b1;
         tick();
         start = 1'b0;
      endtask

      task automatic wait_done(input string name, input int budget, input bit rnd_hold);
         int k;
         k = 0;
         while (done !== 1'b1 && k < budget) begin
            hold = rnd_hold ? ($urandom_range(0, 3) == 0) : 1'b0;
            tick();
            k++;
         end
         hold = 1'b0;
         if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL lat%0d/%s_timeout: got no done in %0d cycles, required done", LAT, name, budget);
         end
      endtask

      task automatic wait_issues(input string name, input int want);
         int n;
         n = 0;
         for (int k = 0; k < 60 && n < want; k++) begin
            tick();
            if (spad_re) n++;
         end
         lchk({name, "_issues_seen"}, 64'(n), 64'(want));
      endtask

      task automatic check_zero(input string name);
         lchk({name, "_re"}, 64'(spad_re), 64'd0);
         lchk({name, "_valid"}, 64'(dv), 64'd0);
         lchk({name, "_busy"}, 64'(busy), 64'd0);
         lchk({name, "_done"}, 64'(done), 64'd0);
         lchk({name, "_spad_addr"}, 64'(spad_addr), 64'd0);
         lchk({name, "_addr"}, 64'(addr), 64'd0);
         lchk({name, "_data"}, data, 64'd0);
      endtask

      initial begin
         logic [AW-1:0] rs;
         int len;

         // Reset state
         rst = 1'b1;
         tick();
         check_zero("reset");
         tick();
         rst = 1'b0;
         tick();

         // Basic pass with latency measurement
         re_cnt = 0;
         first_re_cyc = -1;
         first_dv_cyc = -1;
         start_pass(8'h10, 8'h13);
         lchk("busy_after_start", 64'(busy), 64'd1);
         wait_done("basic", 100, 1'b0);
         lchk("basic_re_count", 64'(re_cnt), 64'd4);
         lchk("basic_first_valid_latency", 64'(first_dv_cyc - first_re_cyc), 64'(LAT + 1));
         tick();
         lchk("done_single_cycle", 64'(done), 64'd0);

         // Wrap-around and single word
         start_pass(8'hFE, 8'h01);
         wait_done("wrap", 100, 1'b0);
         tick();
         start_pass(8'h55, 8'h55);
         wait_done("single", 100, 1'b0);
         tick();

         // Backpressure after the third issue
         start_pass(8'h00, 8'h07);
         wait_issues("bp", 3);
         hold = 1'b1;
         repeat (5) tick();
         hold = 1'b0;
         wait_done("bp", 100, 1'b0);
         tick();

         // Start ignored mid-pass and in the done cycle
         start_pass(8'h80, 8'h8B);
         repeat (4) tick();
         sa = 8'h40;
         ea = 8'h45;
         start = 1'b1;
         tick();
         start = 1'b0;
         wait_done("ign", 100, 1'b0);
         sa = 8'h40;
         ea = 8'h47;
         start = 1'b1;
         tick();
         start = 1'b0;
         lchk("start_in_done_ignored", 64'(busy), 64'd0);
         start_pass(8'h40, 8'h47);
         wait_done("after_done", 100, 1'b0);
         tick();

         // Abort with reads in flight
         start_pass(8'h20, 8'h2F);
         wait_issues("abort", 2);
         clr = 1'b1;
         tick();
         clr = 1'b0;
         exp_q.delete();
         exp_passes--;
         check_zero("abort");
         repeat (12) tick();
         start_pass(8'h00, 8'h03);
         wait_done("post_abort", 100, 1'b0);
         tick();

         // Reset while draining
         start_pass(8'h30, 8'h33);
         wait_issues("rst_drain", 4);
         rst = 1'b1;
         tick();
         rst = 1'b0;
         exp_q.delete();
         exp_passes--;
         check_zero("rst_drain");
         repeat (10) tick();

         // Randomized passes with random backpressure
         repeat (8) begin
            rs = 8'($urandom);
            len = $urandom_range(1, 24);
            start_pass(rs, rs + 8'(len - 1));
            wait_done("rand", 600, 1'b1);
            tick();
            repeat ($urandom_range(0, 3)) tick();
         end

         repeat (6) tick();
         lchk("all_words_emitted", 64'(exp_q.size()), 64'd0);
         lchk("done_count", 64'(seen_passes), 64'(exp_passes));
         lanes_finished++;
      end
   end

   initial begin
      wait (lanes_finished == 2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got no completion by %0t, required completion", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/spad_row_broadcaster.md
Name: spad_row_broadcaster

Overview:
- Read side of the input scratchpad. Walks an inclusive address range, issues one SPAD read per cycle and broadcasts each returned word with its address and a valid strobe to every row router in parallel.
- Its outputs drive the row routers' `i_data`, `i_addr` and `i_data_valid` inputs.
- Row routers apply backpressure through `i_hold`.
- The SPAD macro has a fixed read latency of `SPAD_READ_LATENCY` cycles; the block tracks in-flight reads so that every word is emitted exactly once with the correct address.

Parameters:
- `SPAD_DATA_WIDTH`, 64, width of one SPAD word.
- `ADDR_WIDTH`, 8, SPAD address width.
- `SPAD_READ_LATENCY`, 1, cycles from `o_spad_re` to `i_spad_data` valid. Legal range 1..4.

Ports:
- `i_clk`  input  1  clock
- `i_rst`  input  1  synchronous active-high reset
- `i_reg_clear`  input  1  synchronous abort, same effect as reset
- `i_start`  input  1  one-cycle pulse that latches the range and begins a pass
- `i_start_addr`  input  `ADDR_WIDTH`  first address of the pass
- `i_end_addr`  input  `ADDR_WIDTH`  last address of the pass, inclusive
- `i_hold`  input  1  backpressure; no new read is issued while high
- `o_spad_addr`  output  `ADDR_WIDTH`  SPAD read address
- `o_spad_re`  output  1  SPAD read enable
- `i_spad_data`  input  `SPAD_DATA_WIDTH`  SPAD read data
- `o_data`  output  `SPAD_DATA_WIDTH`  broadcast word
- `o_addr`  output  `ADDR_WIDTH`  address of the broadcast word
- `o_data_valid`  output  1  broadcast strobe
- `o_busy`  output  1  high from the cycle after an accepted start until DONE
- `o_done`  output  1  one-cycle pulse at the end of a pass

Behaviour:
- Reset / clear: `i_rst` or `i_reg_clear` high at a clock edge forces the following state on the next cycle:
  - state IDLE;
  - `o_spad_re`, `o_data_valid`, `o_busy` and `o_done` all 0;
  - `o_spad_addr`, `o_addr` and `o_data` all 0;
  - every in-flight pipeline valid flushed.
  
  Words returning from reads issued before the reset/clear are discarded. `i_rst` takes priority over `i_reg_clear`; the two have identical effect.
- States:
  - IDLE:
    - `i_start` latches `cur_addr = i_start_addr`, `end_addr = i_end_addr` and the remaining count.
    - Remaining count = ((`i_end_addr` - `i_start_addr`) mod 2^`ADDR_WIDTH`) + 1. Width is `ADDR_WIDTH`+1 bits; start == end gives a count of 1.
    - Next state is READ.
  - READ: each cycle with `i_hold` low:
    - `o_spad_re` = 1 and `o_spad_addr` = `cur_addr`;
    - `cur_addr` increments, wrapping modulo 2^`ADDR_WIDTH`;
    - the count decrements.
    
    After the read of the last address is issued, the next state is DRAIN.
  - DRAIN: no reads are issued. Once every in-flight read has been emitted, the next state is DONE.
  - DONE: `o_done` = 1 for exactly one cycle, then IDLE.
- `i_start` is ignored in any state other than IDLE.
- `o_busy` = 1 in READ and DRAIN.
- Issuing and `i_hold`:
  - `o_spad_re` and `o_spad_addr` are registered outputs.
  - `i_hold` is sampled combinationally when deciding whether to issue in the current cycle. When `i_hold` = 1, `o_spad_re` = 0 and `cur_addr` holds.
- Return pipeline:
  - An `ADDR_WIDTH`+1 bit shift register of depth `SPAD_READ_LATENCY` carries {valid, addr} alongside each read.
  - `o_data_valid` is registered: it is asserted one cycle after `i_spad_data` becomes valid. Issue-to-output latency is therefore `SPAD_READ_LATENCY`+1 cycles.
  - At that cycle `o_data` = the captured `i_spad_data` and `o_addr` = the address that was issued for that read.
  - `o_data` and `o_addr` hold their last values while `o_data_valid` = 0.
- Hold semantics:
  - `i_hold` stops only new issues.
  - Reads already in flight (at most `SPAD_READ_LATENCY`) still emit. Row routers must absorb up to `SPAD_READ_LATENCY`+1 words after raising hold.
  - Words are never dropped or duplicated.
- Ordering: words are emitted in strictly increasing address order, modulo wrap, with no gaps other than hold bubbles.
- End of pass: `o_done` rises on the cycle after the final `o_data_valid`.
- Back-to-back passes: an `i_start` arriving in the cycle `o_done` is high is ignored, because the block is not yet in IDLE. An `i_start` one cycle later is accepted.

Test Plan:
- Basic pass:
  - Stimulus: LATENCY=1, SPAD model returns data = {8{addr}}; start=0x10, end=0x13, hold=0.
  - Required: `o_spad_re` high for 4 cycles. `o_data_valid` high for 4 consecutive cycles with `o_addr` 0x10..0x13 and `o_data` 0x1010..10 .. 0x1313..13. First valid comes 2 cycles after the first `o_spad_re`. `o_done` pulses once, on the cycle after the last valid.
- Wrap-around:
  - Stimulus: start=0xFE, end=0x01.
  - Required: 4 words emitted with `o_addr` 0xFE, 0xFF, 0x00, 0x01, then `o_done`.
  - Also: start=end=0x55 → exactly one word, addr 0x55.
- Backpressure:
  - Stimulus: LATENCY=3, range 0x00..0x07; hold=1 for 5 cycles after the 3rd issue.
  - Required: no `o_spad_re` during hold, and the 3 in-flight words are still emitted. Exactly 8 words total with addresses 0..7 in order, no duplicates.
- Abort:
  - Stimulus: `i_reg_clear` pulsed while 2 reads are in flight in a 16-word pass.
  - Required: all outputs 0 next cycle, no `o_data_valid` afterwards, no `o_done`. A new `i_start` is then accepted normally.
- Ignored start:
  - Stimulus: `i_start` with start=0x40 pulsed mid-pass, and again in the `o_done` cycle.
  - Required: the current pass completes unchanged and no second pass starts. A start one cycle after `o_done` runs a full pass.
- Reset mid-operation:
  - Stimulus: `i_rst` asserted in DRAIN.
  - Required: next cycle `o_busy`=0, `o_done`=0, `o_data_valid`=0, `o_spad_addr`=0, and the pending word is not emitted.
